// File: rtl/riscv_parcel_queue.sv
// Instruction-fetch parcel queue: packs valid parcels of each fetched word into a circular
// buffer and presents the two oldest parcels to decode, which pops 0..2 per cycle.
module riscv_parcel_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PARCEL_SIZE = 16,
  parameter int unsigned DEPTH       = 8,
  localparam int unsigned PARCELS    = XLEN / PARCEL_SIZE,
  localparam int unsigned CntW       = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [XLEN-1:0]          parcel_pc_i,
  input  logic [XLEN-1:0]          parcel_i,
  input  logic [PARCELS-1:0]       parcel_valid_i,
  input  logic                     parcel_error_i,
  input  logic                     parcel_misaligned_i,
  input  logic                     parcel_pagefault_i,
  output logic                     almost_full_o,
  output logic                     empty_o,
  output logic [CntW-1:0]          count_o,
  output logic                     overflow_o,
  output logic [2*PARCEL_SIZE-1:0] q_parcel_o,
  output logic [1:0]               q_valid_o,
  output logic [XLEN-1:0]          q_pc_o,
  output logic [1:0]               q_error_o,
  output logic [1:0]               q_misaligned_o,
  output logic [1:0]               q_pagefault_o,
  input  logic [1:0]               pop_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OffW = $clog2(XLEN / 8);

  // Storage is deliberately left unreset; outputs are masked by slot validity instead.
  logic [PARCEL_SIZE-1:0] mem_parcel [DEPTH];
  logic [XLEN-1:0]        mem_pc     [DEPTH];
  logic [2:0]             mem_attr   [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [CntW-1:0]        n_wr, n_rd;
  logic [1:0]             pop_cl;
  logic                   wr_fits, wr_en;
  int                     first;
  logic [XLEN-1:0]        pc_base;
  logic                   wr_sel  [PARCELS];
  logic [PtrW-1:0]        wr_idx  [PARCELS];
  logic [PARCEL_SIZE-1:0] wr_data [PARCELS];
  logic [XLEN-1:0]        wr_pc   [PARCELS];

  logic unused_pc_low;
  assign unused_pc_low = ^parcel_pc_i[OffW-1:0];
  assign pc_base = {parcel_pc_i[XLEN-1:OffW], OffW'(0)};

  // Pack the contiguous valid run starting at the lowest set bit into consecutive entries.
  always_comb begin
    n_wr  = '0;
    first = 0;
    for (int i = PARCELS - 1; i >= 0; i--) begin
      if (parcel_valid_i[i]) first = i;
    end
    for (int i = 0; i < PARCELS; i++) begin
      n_wr = n_wr + CntW'(parcel_valid_i[i]);
    end
    for (int i = 0; i < PARCELS; i++) begin
      wr_sel[i]  = 1'b0;
      wr_idx[i]  = wr_ptr_q + PtrW'(i);
      wr_data[i] = '0;
      wr_pc[i]   = '0;
      if (i < int'(n_wr) && (first + i) < int'(PARCELS)) begin
        wr_sel[i]  = 1'b1;
        wr_data[i] = parcel_i[(first + i) * PARCEL_SIZE +: PARCEL_SIZE];
        wr_pc[i]   = pc_base + XLEN'((first + i) * (PARCEL_SIZE / 8));
      end
    end
  end

  always_comb begin
    pop_cl     = (pop_i == 2'd3) ? 2'd2 : pop_i;
    n_rd       = (CntW'(pop_cl) > count_q) ? count_q : CntW'(pop_cl);
    // Space released by this cycle's pop is available to this cycle's write.
    wr_fits    = int'(n_wr) <= (int'(DEPTH) - int'(count_q) + int'(n_rd));
    wr_en      = (n_wr != '0) && wr_fits;
    rd_ptr_d   = rd_ptr_q + PtrW'(n_rd);
    wr_ptr_d   = wr_en ? (wr_ptr_q + PtrW'(n_wr)) : wr_ptr_q;
    count_d    = count_q - n_rd + (wr_en ? n_wr : '0);
    overflow_d = overflow_q | ((n_wr != '0) && !wr_fits);
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && wr_en) begin
      for (int i = 0; i < PARCELS; i++) begin
        if (wr_sel[i]) begin
          mem_parcel[wr_idx[i]] <= wr_data[i];
          mem_pc[wr_idx[i]]     <= wr_pc[i];
          mem_attr[wr_idx[i]]   <= {parcel_pagefault_i, parcel_misaligned_i, parcel_error_i};
        end
      end
    end
  end

  logic [PtrW-1:0] rd_idx1;
  logic [2:0]      attr0, attr1;

  always_comb begin
    rd_idx1        = rd_ptr_q + PtrW'(1);
    q_valid_o      = {count_q >= CntW'(2), count_q >= CntW'(1)};
    q_parcel_o     = '0;
    q_pc_o         = '0;
    attr0          = '0;
    attr1          = '0;
    if (q_valid_o[0]) begin
      q_parcel_o[PARCEL_SIZE-1:0] = mem_parcel[rd_ptr_q];
      q_pc_o                      = mem_pc[rd_ptr_q];
      attr0                       = mem_attr[rd_ptr_q];
    end
    if (q_valid_o[1]) begin
      q_parcel_o[2*PARCEL_SIZE-1:PARCEL_SIZE] = mem_parcel[rd_idx1];
      attr1                                   = mem_attr[rd_idx1];
    end
    q_error_o      = {attr1[0], attr0[0]};
    q_misaligned_o = {attr1[1], attr0[1]};
    q_pagefault_o  = {attr1[2], attr0[2]};
  end

  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (CntW'(DEPTH) - count_q) < CntW'(PARCELS);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_riscv_parcel_queue.sv
// Directed plus random bench for riscv_parcel_queue against a queue-based reference model.
module tb_riscv_parcel_queue;

  localparam int XLEN    = 32;
  localparam int PSIZE   = 16;
  localparam int DEPTH   = 8;
  localparam int PARCELS = XLEN / PSIZE;

  logic              clk_i = 1'b0;
  logic              rst_i, flush_i;
  logic [XLEN-1:0]   parcel_pc_i, parcel_i;
  logic [1:0]        parcel_valid_i;
  logic              parcel_error_i, parcel_misaligned_i, parcel_pagefault_i;
  logic              almost_full_o, empty_o, overflow_o;
  logic [3:0]        count_o;
  logic [31:0]       q_parcel_o;
  logic [1:0]        q_valid_o;
  logic [XLEN-1:0]   q_pc_o;
  logic [1:0]        q_error_o, q_misaligned_o, q_pagefault_o;
  logic [1:0]        pop_i;

  riscv_parcel_queue #(.XLEN(XLEN), .PARCEL_SIZE(PSIZE), .DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .parcel_pc_i         (parcel_pc_i),
    .parcel_i            (parcel_i),
    .parcel_valid_i      (parcel_valid_i),
    .parcel_error_i      (parcel_error_i),
    .parcel_misaligned_i (parcel_misaligned_i),
    .parcel_pagefault_i  (parcel_pagefault_i),
    .almost_full_o       (almost_full_o),
    .empty_o             (empty_o),
    .count_o             (count_o),
    .overflow_o          (overflow_o),
    .q_parcel_o          (q_parcel_o),
    .q_valid_o           (q_valid_o),
    .q_pc_o              (q_pc_o),
    .q_error_o           (q_error_o),
    .q_misaligned_o      (q_misaligned_o),
    .q_pagefault_o       (q_pagefault_o),
    .pop_i               (pop_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] d;
    logic [31:0] pc;
    logic        e, m, p;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int          sz;
    logic [31:0] ep;
    logic [1:0]  ee, em, epf;
    sz  = mq.size();
    ep  = '0;
    ee  = '0;
    em  = '0;
    epf = '0;
    if (sz >= 1) begin
      ep[15:0] = mq[0].d;
      ee[0] = mq[0].e; em[0] = mq[0].m; epf[0] = mq[0].p;
    end
    if (sz >= 2) begin
      ep[31:16] = mq[1].d;
      ee[1] = mq[1].e; em[1] = mq[1].m; epf[1] = mq[1].p;
    end
    chk("count", 64'(count_o), 64'(sz));
    chk("empty", 64'(empty_o), 64'(sz == 0));
    chk("almost_full", 64'(almost_full_o), 64'((DEPTH - sz) < PARCELS));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("q_valid", 64'(q_valid_o), 64'({sz >= 2, sz >= 1}));
    chk("q_parcel", 64'(q_parcel_o), 64'(ep));
    chk("q_pc", 64'(q_pc_o), (sz >= 1) ? 64'(mq[0].pc) : 64'(0));
    chk("q_error", 64'(q_error_o), 64'(ee));
    chk("q_misaligned", 64'(q_misaligned_o), 64'(em));
    chk("q_pagefault", 64'(q_pagefault_o), 64'(epf));
  endtask

  // One clock: drive, advance the model by the queue rules, then compare just after the edge.
  task automatic step(input logic [1:0] v, input logic [31:0] pc, input logic [31:0] data,
                      input logic e, input logic m, input logic p, input logic [1:0] pop,
                      input logic fl, input logic rs);
    int nrd, nwr;
    parcel_valid_i = v; parcel_pc_i = pc; parcel_i = data;
    parcel_error_i = e; parcel_misaligned_i = m; parcel_pagefault_i = p;
    pop_i = pop; flush_i = fl; rst_i = rs;
    @(posedge clk_i);
    if (rs || fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      nrd = (pop == 2'd3) ? 2 : int'(pop);
      if (nrd > mq.size()) nrd = mq.size();
      nwr = int'(v[0]) + int'(v[1]);
      repeat (nrd) void'(mq.pop_front());
      if (nwr > DEPTH - mq.size()) m_ovf = 1'b1;
      else begin
        for (int k = 0; k < PARCELS; k++) begin
          if (v[k]) mq.push_back('{data[k*16 +: 16], (pc & 32'hFFFF_FFFC) + 32'(2 * k), e, m, p});
        end
      end
    end
    #1;
    check_model();
  endtask

  task automatic idle(input logic [1:0] pop);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, pop, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] v, input logic [31:0] pc, input logic [31:0] data,
                    input logic [1:0] pop);
    step(v, pc, data, 1'b0, 1'b0, 1'b0, pop, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(2'b11, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
  endtask

  initial begin
    m_ovf = 1'b0;
    rst_i = 1'b1; flush_i = 1'b0; pop_i = '0; parcel_valid_i = '0;
    parcel_pc_i = '0; parcel_i = '0;
    parcel_error_i = 1'b0; parcel_misaligned_i = 1'b0; parcel_pagefault_i = 1'b0;

    do_reset();
    chk("reset_empty", 64'(empty_o), 64'(1));
    chk("reset_q_parcel", 64'(q_parcel_o), 64'(0));

    // Full-word write
    wr(2'b11, 32'h100, 32'hBBBB_AAAA, 2'd0);
    chk("t1_parcel", 64'(q_parcel_o), 64'h0000_0000_BBBB_AAAA);
    chk("t1_pc", 64'(q_pc_o), 64'h100);

    // Upper parcel only, then over-pop
    do_reset();
    wr(2'b10, 32'h204, 32'h1234_5678, 2'd0);
    chk("t2_pc", 64'(q_pc_o), 64'h206);
    chk("t2_valid", 64'(q_valid_o), 64'b01);
    idle(2'd2);
    chk("t2_empty", 64'(empty_o), 64'(1));

    // Fill to 7, dropped write, then accepted with pop
    do_reset();
    for (int i = 0; i < 3; i++) wr(2'b11, 32'h400 + 32'(4 * i), 32'h1000_0000 + 32'(i), 2'd0);
    wr(2'b01, 32'h40C, 32'hAAAA_5555, 2'd0);
    chk("t3_afull", 64'(almost_full_o), 64'(1));
    wr(2'b11, 32'h410, 32'h7777_6666, 2'd0);
    chk("t3_ovf", 64'(overflow_o), 64'(1));
    chk("t3_cnt7", 64'(count_o), 64'(7));
    wr(2'b11, 32'h410, 32'h7777_6666, 2'd1);
    chk("t3_cnt8", 64'(count_o), 64'(8));
    wr(2'b11, 32'h414, 32'h9999_8888, 2'd2);
    chk("t3_full_pp", 64'(count_o), 64'(8));

    // Wrap write splitting across entries 7 and 0
    do_reset();
    for (int i = 0; i < 7; i++) wr(2'b01, 32'h500 + 32'(4 * i), 32'h0000_0A00 + 32'(i), 2'd1);
    idle(2'd1);
    wr(2'b11, 32'h300, 32'hCAFE_F00D, 2'd0);
    chk("t4_pc0", 64'(q_pc_o), 64'h300);
    idle(2'd1);
    chk("t4_pc1", 64'(q_pc_o), 64'h302);
    chk("t4_data1", 64'(q_parcel_o), 64'h0000_0000_0000_CAFE);

    // Attribute replication and clearing
    do_reset();
    step(2'b11, 32'h600, 32'h2222_1111, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("t5_err", 64'(q_error_o), 64'b11);
    chk("t5_pf", 64'(q_pagefault_o), 64'b11);
    wr(2'b11, 32'h604, 32'h4444_3333, 2'd2);
    chk("t5_err_clr", 64'(q_error_o), 64'b00);

    // Flush and reset mid-stream
    do_reset();
    wr(2'b11, 32'h700, 32'h1, 2'd0);
    wr(2'b11, 32'h704, 32'h2, 2'd0);
    wr(2'b01, 32'h708, 32'h3, 2'd0);
    chk("t6_cnt5", 64'(count_o), 64'(5));
    step(2'b11, 32'h70C, 32'h4, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    chk("t6_flush", 64'(count_o), 64'(0));
    wr(2'b11, 32'h710, 32'h5, 2'd0);
    do_reset();
    chk("t6_rst", 64'(empty_o), 64'(1));

    // Random traffic; first half pops slowly to exercise full/overflow
    for (int it = 0; it < 500; it++) begin
      step(2'($urandom_range(0, 3)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'((it < 250) ? $urandom_range(0, 1) : $urandom_range(0, 3)),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
